pipe_collision_scorer: RTL

Parametrised successor to the single-pipe collision checker. It evaluates the bird against `NUM_PIPES` pipes, plus the screen ceiling and floor, once per frame tick. It keeps a saturating score of pipes passed. It sits between the pipe generator and bird physics on one side and the display/score blocks on the other, and owns the Initial/Play/Lose game state.

---
 rtl/flappy_pkg.sv | 16 +
 rtl/pipe_collision_scorer_if.sv | 39 +++
 rtl/pipe_hit_check.sv | 61 ++++++
 rtl/pipe_collision_scorer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the pipe collision scorer.
//   state_t : game / scan state encoding
//   EXT_PAD : extra bits added to coordinates before signed comparisons
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_WAIT,
        ST_SCAN,
        ST_LOSE
    } state_t;

    // Coordinates are compared at COORD_W+EXT_PAD bits so that sums never wrap.
    localparam int EXT_PAD = 2;

endpackage

// File: rtl/pipe_collision_scorer_if.sv
// Bus between the pipe generator / bird physics, the scorer and the
// display / score blocks.
//   master : drives Start/Ack/Tick, bird and pipe coordinates
//   slave  : the scorer, drives game state, score and scan results
interface pipe_collision_scorer_if #(
    parameter int NUM_PIPES = 3,
    parameter int COORD_W   = 10,
    parameter int SCORE_W   = 8
);
    localparam int IDX_W = $clog2(NUM_PIPES + 1);

    logic                         Start;
    logic                         Ack;
    logic                         Tick;
    logic signed [COORD_W-1:0]    Bird_X;
    logic signed [COORD_W-1:0]    Bird_Y;
    logic [NUM_PIPES*COORD_W-1:0] Pipe_X;
    logic [NUM_PIPES*COORD_W-1:0] Pipe_Y;

    logic                         Q_Initial;
    logic                         Q_Play;
    logic                         Q_Lose;
    logic                         Lose;
    logic [SCORE_W-1:0]           Score;
    logic                         Score_Inc;
    logic [IDX_W-1:0]             Hit_Idx;
    logic                         Frame_Done;

    modport master (
        output Start, Ack, Tick, Bird_X, Bird_Y, Pipe_X, Pipe_Y,
        input  Q_Initial, Q_Play, Q_Lose, Lose, Score, Score_Inc, Hit_Idx, Frame_Done
    );

    modport slave (
        input  Start, Ack, Tick, Bird_X, Bird_Y, Pipe_X, Pipe_Y,
        output Q_Initial, Q_Play, Q_Lose, Lose, Score, Score_Inc, Hit_Idx, Frame_Done
    );

endinterface

// File: rtl/pipe_hit_check.sv
// Combinational bird-versus-one-pipe evaluation.
//   bird_x/bird_y : bird top-left corner (signed)
//   pipe_x/pipe_y : pipe left edge and gap top edge (unsigned)
//   passed        : pipe already counted
//   hit           : bird overlaps the pipe outside its gap
//   pass          : bird fully right of an uncounted pipe
//   clear_passed  : bird not yet right of the pipe (re-arms the pass)
//   bound_hit     : bird outside the ceiling/floor
module pipe_hit_check
    import flappy_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int PIPE_W   = 80,
    parameter int GAP_H    = 100,
    parameter int BIRD_W   = 16,
    parameter int BIRD_H   = 16,
    parameter int SCREEN_H = 480
) (
    input  logic signed [COORD_W-1:0] bird_x,
    input  logic signed [COORD_W-1:0] bird_y,
    input  logic [COORD_W-1:0]        pipe_x,
    input  logic [COORD_W-1:0]        pipe_y,
    input  logic                      passed,
    output logic                      hit,
    output logic                      pass,
    output logic                      clear_passed,
    output logic                      bound_hit
);
    localparam int E = COORD_W + EXT_PAD;

    localparam logic signed [E-1:0] K_PIPE_W   = E'(PIPE_W);
    localparam logic signed [E-1:0] K_GAP_H    = E'(GAP_H);
    localparam logic signed [E-1:0] K_BIRD_W   = E'(BIRD_W);
    localparam logic signed [E-1:0] K_BIRD_H   = E'(BIRD_H);
    localparam logic signed [E-1:0] K_SCREEN_H = E'(SCREEN_H);

    logic signed [E-1:0] bx, by, px, py;
    logic signed [E-1:0] bird_r, bird_b, pipe_r, gap_b;
    logic                x_overlap, out_of_gap;

    always_comb begin
        bx = {{EXT_PAD{bird_x[COORD_W-1]}}, bird_x};
        by = {{EXT_PAD{bird_y[COORD_W-1]}}, bird_y};
        px = {{EXT_PAD{1'b0}}, pipe_x};
        py = {{EXT_PAD{1'b0}}, pipe_y};

        bird_r = bx + K_BIRD_W;
        bird_b = by + K_BIRD_H;
        pipe_r = px + K_PIPE_W;
        gap_b  = py + K_GAP_H;

        x_overlap  = (bird_r > px) && (bx < pipe_r);
        out_of_gap = (by < py) || (bird_b > gap_b);

        hit          = x_overlap && out_of_gap;
        pass         = (bx >= pipe_r) && !passed;
        clear_passed = (bx < pipe_r);
        bound_hit    = (by < 0) || (bird_b > K_SCREEN_H);
    end

endmodule

// File: rtl/pipe_collision_scorer.sv
// Game state (Initial/Play/Lose) and per-frame collision scan over
// NUM_PIPES pipes, one pipe per cycle, with a saturating pass score.
//   Clk, reset : clock, synchronous active-high reset
//   bus        : slave side of pipe_collision_scorer_if
module pipe_collision_scorer
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = 3,
    parameter int COORD_W   = 10,
    parameter int PIPE_W    = 80,
    parameter int GAP_H     = 100,
    parameter int BIRD_W    = 16,
    parameter int BIRD_H    = 16,
    parameter int SCREEN_H  = 480,
    parameter int SCORE_W   = 8
) (
    input  logic               Clk,
    input  logic               reset,
    pipe_collision_scorer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PIPES + 1);

    state_t                       state, state_nxt;
    logic [IDX_W-1:0]             idx;
    logic [NUM_PIPES-1:0]         passed;
    logic [SCORE_W-1:0]           score;
    logic                         score_inc;
    logic                         frame_done;
    logic [IDX_W-1:0]             hit_idx;

    logic signed [COORD_W-1:0]    snap_bx, snap_by;
    logic [NUM_PIPES*COORD_W-1:0] snap_px, snap_py;

    logic [COORD_W-1:0]           cur_px, cur_py;
    logic                         cur_passed;
    logic                         hit, pass, clear_passed, bound_hit;
    logic                         bound_loss, scan_hit, scan_last;

    // Select the snapshotted pipe under evaluation.
    always_comb begin
        cur_px     = '0;
        cur_py     = '0;
        cur_passed = 1'b0;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_px     = snap_px[i*COORD_W +: COORD_W];
                cur_py     = snap_py[i*COORD_W +: COORD_W];
                cur_passed = passed[i];
            end
        end
    end

    pipe_hit_check #(
        .COORD_W (COORD_W),
        .PIPE_W  (PIPE_W),
        .GAP_H   (GAP_H),
        .BIRD_W  (BIRD_W),
        .BIRD_H  (BIRD_H),
        .SCREEN_H(SCREEN_H)
    ) u_check (
        .bird_x      (snap_bx),
        .bird_y      (snap_by),
        .pipe_x      (cur_px),
        .pipe_y      (cur_py),
        .passed      (cur_passed),
        .hit         (hit),
        .pass        (pass),
        .clear_passed(clear_passed),
        .bound_hit   (bound_hit)
    );

    always_comb begin
        bound_loss = bound_hit && (idx == '0);
        scan_hit   = bound_loss || hit;
        scan_last  = (idx == IDX_W'(NUM_PIPES - 1));

        state_nxt = state;
        case (state)
            ST_INIT: if (bus.Start) state_nxt = ST_WAIT;
            ST_WAIT: if (bus.Tick)  state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (scan_hit)       state_nxt = ST_LOSE;
                else if (scan_last) state_nxt = ST_WAIT;
            end
            ST_LOSE: if (bus.Ack)   state_nxt = ST_INIT;
            default:                state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= ST_INIT;
            idx        <= '0;
            passed     <= '0;
            score      <= '0;
            score_inc  <= 1'b0;
            frame_done <= 1'b0;
            hit_idx    <= '0;
            snap_bx    <= '0;
            snap_by    <= '0;
            snap_px    <= '0;
            snap_py    <= '0;
        end else begin
            state      <= state_nxt;
            score_inc  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (bus.Start) begin
                        score   <= '0;
                        passed  <= '0;
                        hit_idx <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.Tick) begin
                        snap_bx <= bus.Bird_X;
                        snap_by <= bus.Bird_Y;
                        snap_px <= bus.Pipe_X;
                        snap_py <= bus.Pipe_Y;
                        idx     <= '0;
                    end
                end
                ST_SCAN: begin
                    // Ceiling/floor takes precedence over pipe 0 in the first cycle.
                    if (bound_loss) begin
                        hit_idx <= IDX_W'(NUM_PIPES);
                    end else if (hit) begin
                        hit_idx <= idx;
                    end else begin
                        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                            if (idx == IDX_W'(i)) begin
                                if (pass)              passed[i] <= 1'b1;
                                else if (clear_passed) passed[i] <= 1'b0;
                            end
                        end
                        if (pass) begin
                            score_inc <= 1'b1;
                            if (score != '1) score <= score + 1'b1;
                        end
                        if (scan_last) frame_done <= 1'b1;
                        else           idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Q_Initial  = (state == ST_INIT);
    assign bus.Q_Play     = (state == ST_WAIT) || (state == ST_SCAN);
    assign bus.Q_Lose     = (state == ST_LOSE);
    assign bus.Lose       = (state == ST_LOSE);
    assign bus.Score      = score;
    assign bus.Score_Inc  = score_inc;
    assign bus.Hit_Idx    = hit_idx;
    assign bus.Frame_Done = frame_done;

endmodule
